// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - game state codes, map indices, screen size and plot tag type
package game_pkg;

  localparam int SCREEN_WIDTH  = 320;
  localparam int SCREEN_HEIGHT = 240;

  localparam logic [3:0] GS_UPDATE_BRIDGE_1 = 4'd1;
  localparam logic [3:0] GS_UPDATE_BRIDGE_2 = 4'd3;
  localparam logic [3:0] GS_UPDATE_BRIDGE_3 = 4'd5;
  localparam logic [3:0] GS_UPDATE_PILLAR   = 4'd7;
  localparam logic [3:0] GS_FINISHED_GAME   = 4'd9;
  localparam logic [3:0] GS_DRAW_INITIAL    = 4'd10;

  localparam logic [2:0] MAP_INITIAL  = 3'd0;
  localparam logic [2:0] MAP_BRIDGE_1 = 3'd1;
  localparam logic [2:0] MAP_BRIDGE_2 = 3'd2;
  localparam logic [2:0] MAP_BRIDGE_3 = 3'd3;
  localparam logic [2:0] MAP_PILLAR   = 3'd4;
  localparam logic [2:0] MAP_FINISHED = 3'd5;

  typedef struct packed {
    logic       valid;
    logic [8:0] x;
    logic [7:0] y;
  } plot_tag_t;

  // Unlisted codes fall back to the initial map.
  function automatic logic [2:0] map_index(input logic [3:0] gs);
    case (gs)
      GS_DRAW_INITIAL:    return MAP_INITIAL;
      GS_UPDATE_BRIDGE_1: return MAP_BRIDGE_1;
      GS_UPDATE_BRIDGE_2: return MAP_BRIDGE_2;
      GS_UPDATE_BRIDGE_3: return MAP_BRIDGE_3;
      GS_UPDATE_PILLAR:   return MAP_PILLAR;
      GS_FINISHED_GAME:   return MAP_FINISHED;
      default:            return MAP_INITIAL;
    endcase
  endfunction

endpackage

// File: rtl/plot_delay_pipe.sv
// rtl/plot_delay_pipe.sv - LAT-deep shift register aligning {valid, x, y} with a ROM read
module plot_delay_pipe
  import game_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic      clock,
  input  logic      resetn,
  input  plot_tag_t tag_in,
  output plot_tag_t tag_out
);

  plot_tag_t stage [LAT];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < LAT; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[LAT-1];

endmodule

// File: rtl/map_redraw_engine.sv
// rtl/map_redraw_engine.sv - sweeps the background ROM over the whole frame and plots every pixel
module map_redraw_engine
  import game_pkg::*;
#(
  parameter int WIDTH    = SCREEN_WIDTH,
  parameter int HEIGHT   = SCREEN_HEIGHT,
  parameter int COLOUR_W = 9,
  parameter int ROM_LAT  = 1
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                drawMap,
  input  logic [3:0]          gameState,
  output logic [2:0]          map_sel,
  output logic [16:0]         rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [8:0]          x,
  output logic [7:0]          y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                doneRedraw,
  output logic                busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int         DW     = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [8:0] X_LAST = 9'(WIDTH - 1);
  localparam logic [7:0] Y_LAST = 8'(HEIGHT - 1);
  localparam logic [DW-1:0] D_LAST = DW'(ROM_LAT - 1);

  logic [1:0]    fsm;
  logic [3:0]    state_q;
  logic [8:0]    cx;
  logic [7:0]    cy;
  logic [DW-1:0] drain_cnt;
  logic          last_pixel;
  plot_tag_t     tag_in;
  plot_tag_t     tag_out;

  assign last_pixel = (cx == X_LAST) && (cy == Y_LAST);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      fsm       <= S_IDLE;
      state_q   <= '0;
      map_sel   <= '0;
      cx        <= '0;
      cy        <= '0;
      rom_addr  <= '0;
      drain_cnt <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (drawMap) begin
            state_q  <= gameState;
            map_sel  <= map_index(gameState);
            cx       <= '0;
            cy       <= '0;
            rom_addr <= '0;
            fsm      <= S_SWEEP;
          end
        end
        // Inputs are deliberately ignored until DONE so a frame is never torn.
        S_SWEEP: begin
          if (last_pixel) begin
            drain_cnt <= '0;
            fsm       <= S_DRAIN;
          end else begin
            rom_addr <= rom_addr + 17'd1;
            if (cx == X_LAST) begin
              cx <= '0;
              cy <= cy + 8'd1;
            end else begin
              cx <= cx + 9'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt == D_LAST) fsm <= S_DONE;
          else                     drain_cnt <= drain_cnt + 1'b1;
        end
        S_DONE: begin
          if (!drawMap || (gameState != state_q)) fsm <= S_IDLE;
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  assign tag_in = '{valid: (fsm == S_SWEEP), x: cx, y: cy};

  plot_delay_pipe #(.LAT(ROM_LAT)) u_pipe (
    .clock  (clock),
    .resetn (resetn),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Gating keeps colour at zero whenever nothing is being plotted, including reset.
  assign plot       = tag_out.valid;
  assign x          = tag_out.x;
  assign y          = tag_out.y;
  assign colour     = plot ? rom_data : '0;
  assign doneRedraw = (fsm == S_DONE);
  assign busy       = (fsm == S_SWEEP) || (fsm == S_DRAIN);

endmodule

// File: tb/tb_map_redraw_engine.sv
// tb/tb_map_redraw_engine.sv - self-checking bench for map_redraw_engine at ROM latencies 1 and 3
module tb_map_redraw_engine;

  localparam int W = 16;
  localparam int H = 8;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       resetn;
  logic       drawMap;
  logic [3:0] gameState;

  logic [2:0]  map_sel  [2];
  logic [16:0] rom_addr [2];
  logic [8:0]  rom_data [2];
  logic [8:0]  x        [2];
  logic [7:0]  y        [2];
  logic [8:0]  colour   [2];
  logic        plot     [2];
  logic        done     [2];
  logic        busy     [2];

  always #5 clk = ~clk;

  map_redraw_engine #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(9), .ROM_LAT(1)) dut_l1 (
    .clock(clk), .resetn(resetn), .drawMap(drawMap), .gameState(gameState),
    .map_sel(map_sel[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]),
    .x(x[0]), .y(y[0]), .colour(colour[0]), .plot(plot[0]),
    .doneRedraw(done[0]), .busy(busy[0])
  );

  map_redraw_engine #(.WIDTH(W), .HEIGHT(H), .COLOUR_W(9), .ROM_LAT(3)) dut_l3 (
    .clock(clk), .resetn(resetn), .drawMap(drawMap), .gameState(gameState),
    .map_sel(map_sel[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]),
    .x(x[1]), .y(y[1]), .colour(colour[1]), .plot(plot[1]),
    .doneRedraw(done[1]), .busy(busy[1])
  );

  // ROM models: data is the low 9 address bits, delivered after the configured latency.
  logic [16:0] hist_l1;
  logic [16:0] hist_l3 [3];
  always @(posedge clk) begin
    hist_l1    <= rom_addr[0];
    hist_l3[0] <= rom_addr[1];
    hist_l3[1] <= hist_l3[0];
    hist_l3[2] <= hist_l3[1];
  end
  assign rom_data[0] = hist_l1[8:0];
  assign rom_data[1] = hist_l3[2][8:0];

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Frame monitor: the k-th plot of a frame must be pixel k in raster order.
  int cyc = 0;
  int c0  = 0;
  int nplot [2];
  int bad [2];
  int first_cyc [2];
  int last_cyc [2];
  int done_cyc [2];
  int done_len [2];
  logic [16:0] addr_first [2];
  logic [16:0] addr_last [2];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (cyc - c0 == 1) addr_first[d] = rom_addr[d];
      if (cyc - c0 == N) addr_last[d] = rom_addr[d];
      if (plot[d]) begin
        if (int'(x[d]) != nplot[d] % W || int'(y[d]) != nplot[d] / W ||
            int'(colour[d]) != ((nplot[d] / W) * W + nplot[d] % W) % 512)
          bad[d]++;
        if (nplot[d] == 0) first_cyc[d] = cyc - c0;
        else if (cyc - c0 != last_cyc[d] + 1) bad[d]++;
        last_cyc[d] = cyc - c0;
        nplot[d]++;
      end
      if (done[d]) begin
        done_len[d]++;
        if (done_cyc[d] < 0) done_cyc[d] = cyc - c0;
      end
    end
  end

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      nplot[d] = 0; bad[d] = 0; first_cyc[d] = -1; last_cyc[d] = -1;
      done_cyc[d] = -1; done_len[d] = 0;
    end
  endtask

  // Call just after a rising edge: this cycle becomes cycle 0.
  task automatic start_frame(input logic [3:0] gs);
    clear_mon();
    c0        = cyc;
    gameState = gs;
    drawMap   = 1'b1;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < N + 20; i++) begin
      @(negedge clk); #1;
      if (done_cyc[0] >= 0 && done_cyc[1] >= 0) break;
    end
    check({name, "_done_seen"}, int'(done_cyc[0] >= 0 && done_cyc[1] >= 0), 1);
  endtask

  task automatic wait_plots(input string name, input int n);
    for (int i = 0; i < N + 20; i++) begin
      @(posedge clk); #1;
      if (nplot[0] >= n) break;
    end
    check({name, "_plots_reached"}, int'(nplot[0] >= n), 1);
  endtask

  task automatic frame_checks(input string tag, input int exp_sel);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_map_sel", tag, d), int'(map_sel[d]), exp_sel);
      check($sformatf("%s_d%0d_plots", tag, d), nplot[d], N);
      check($sformatf("%s_d%0d_pixel_errs", tag, d), bad[d], 0);
      check($sformatf("%s_d%0d_first_plot_cyc", tag, d), first_cyc[d], 1 + lat(d));
      check($sformatf("%s_d%0d_last_plot_cyc", tag, d), last_cyc[d], N + lat(d));
      check($sformatf("%s_d%0d_done_cyc", tag, d), done_cyc[d], N + 1 + lat(d));
      check($sformatf("%s_d%0d_addr_first", tag, d), int'(addr_first[d]), 0);
      check($sformatf("%s_d%0d_addr_last", tag, d), int'(addr_last[d]), N - 1);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_d%0d_flags", tag, d), int'({plot[d], done[d], busy[d]}), 0);
      check($sformatf("%s_d%0d_x", tag, d), int'(x[d]), 0);
      check($sformatf("%s_d%0d_y", tag, d), int'(y[d]), 0);
      check($sformatf("%s_d%0d_colour", tag, d), int'(colour[d]), 0);
      check($sformatf("%s_d%0d_rom_addr", tag, d), int'(rom_addr[d]), 0);
      check($sformatf("%s_d%0d_map_sel", tag, d), int'(map_sel[d]), 0);
    end
  endtask

  typedef struct {
    logic [3:0] gs;
    int         exp_sel;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   map_of [16];
    vec_t vecs [$];
    logic [3:0] rgs;

    for (int i = 0; i < 16; i++) map_of[i] = 0;
    map_of[1] = 1; map_of[3] = 2; map_of[5] = 3; map_of[7] = 4; map_of[9] = 5;

    vecs.push_back('{4'd10, 0});
    vecs.push_back('{4'd1, 1});
    vecs.push_back('{4'd3, 2});
    vecs.push_back('{4'd5, 3});
    vecs.push_back('{4'd7, 4});
    vecs.push_back('{4'd9, 5});
    vecs.push_back('{4'd0, 0});
    vecs.push_back('{4'd15, 0});
    for (int i = 0; i < 4; i++) begin
      rgs = 4'($urandom_range(0, 15));
      vecs.push_back('{rgs, map_of[rgs]});
    end

    clear_mon();
    resetn = 1'b1; drawMap = 1'b0; gameState = 4'd0;
    #1 resetn = 1'b0;
    #1 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      start_frame(vecs[i].gs);
      wait_done($sformatf("vec%0d", i));
      frame_checks($sformatf("vec%0d_gs%0d", i, vecs[i].gs), vecs[i].exp_sel);
      @(posedge clk); #1;
      drawMap = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("vec%0d_done_cleared", i), int'(done[0] | done[1]), 0);
    end

    // Held request through DONE, then a state change with drawMap low.
    @(posedge clk); #1;
    start_frame(4'd3);
    wait_done("hold3");
    @(posedge clk); #1;
    gameState = 4'd4; drawMap = 1'b0;
    @(negedge clk); #1;
    check("hold3_done_exit_cycle", int'(done[0] & done[1]), 1);
    @(negedge clk); #1;
    check("hold3_done_after_exit", int'(done[0] | done[1]), 0);
    clear_mon();
    repeat (20) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("hold3_d%0d_no_new_plots", d), nplot[d], 0);
      check($sformatf("hold3_d%0d_map_sel", d), int'(map_sel[d]), 2);
      check($sformatf("hold3_d%0d_busy", d), int'(busy[d]), 0);
    end

    // drawMap dropped mid-sweep: frame completes, done pulses once.
    @(posedge clk); #1;
    start_frame(4'd5);
    wait_plots("drop", 40);
    drawMap = 1'b0;
    wait_done("drop");
    repeat (6) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("drop_d%0d_plots", d), nplot[d], N);
      check($sformatf("drop_d%0d_pixel_errs", d), bad[d], 0);
      check($sformatf("drop_d%0d_done_len", d), done_len[d], 1);
      check($sformatf("drop_d%0d_map_sel", d), int'(map_sel[d]), 3);
    end

    // FINISHED_GAME held high: one redraw, then DONE indefinitely.
    @(posedge clk); #1;
    start_frame(4'd9);
    wait_done("fin");
    frame_checks("fin", 5);
    clear_mon();
    repeat (2000) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("fin_d%0d_done_len", d), done_len[d], 2000);
      check($sformatf("fin_d%0d_no_plots", d), nplot[d], 0);
      check($sformatf("fin_d%0d_map_sel", d), int'(map_sel[d]), 5);
    end
    @(posedge clk); #1;
    drawMap = 1'b0;
    repeat (2) @(posedge clk);

    // Reset mid-sweep: outputs clear asynchronously, then a clean restart.
    @(posedge clk); #1;
    start_frame(4'd7);
    wait_plots("rst", 50);
    #2 resetn = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); #1;
    resetn = 1'b1;
    start_frame(4'd10);
    wait_done("restart");
    frame_checks("restart", 0);
    @(posedge clk); #1;
    drawMap = 1'b0;
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
